// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared opcodes, address width and controller state encoding
package fetch_sequencer_pkg;
  localparam int ADDR_W = 12;
  localparam logic [3:0] OP_JMP = 4'hF;
  localparam logic [3:0] OP_JC = 4'hE;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    JUMP   = 3'd3,
    SKIP   = 3'd4,
    ISSUE  = 3'd5
  } state_t;
endpackage

// File: rtl/fetch_sequencer_jump_decode.sv
// fetch_sequencer_jump_decode: classifies an opcode as taken jump and/or two-byte instruction
module fetch_sequencer_jump_decode
  import fetch_sequencer_pkg::*;
(
  input  logic [3:0] inst,
  input  logic       carry,
  output logic       take_jump,
  output logic       is_two_byte
);
  assign is_two_byte = inst == OP_JMP || inst == OP_JC;
  assign take_jump = inst == OP_JMP || (inst == OP_JC && carry);
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: Moore controller driving PC/ROM/fetch-register strobes and issuing instructions
module fetch_sequencer
  import fetch_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [3:0]        inst,
  input  logic [3:0]        oprnd,
  input  logic [7:0]        program_byte,
  input  logic              carry,
  input  logic              issue_ready,
  output logic              enable_counter,
  output logic              enable_fetch,
  output logic              load_counter,
  output logic [ADDR_W-1:0] in_counter,
  output logic              issue_valid,
  output logic              busy
);
  state_t state, state_next;
  logic take_jump, is_two_byte;
  fetch_sequencer_jump_decode u_dec (
    .inst(inst),
    .carry(carry),
    .take_jump(take_jump),
    .is_two_byte(is_two_byte)
  );
  always_ff @(posedge clk) state <= reset ? IDLE : state_next;
  // run is only consulted at instruction boundaries
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       state_next = run ? FETCH : IDLE;
      FETCH:      state_next = DECODE;
      DECODE:     state_next = take_jump ? JUMP : is_two_byte ? SKIP : ISSUE;
      JUMP, SKIP: state_next = run ? FETCH : IDLE;
      ISSUE:      state_next = issue_ready ? (run ? FETCH : IDLE) : ISSUE;
      default:    state_next = IDLE;
    endcase
  end
  assign enable_fetch = state == FETCH;
  assign enable_counter = state == FETCH || state == SKIP;
  assign load_counter = state == JUMP;
  assign in_counter = load_counter ? {oprnd, program_byte} : '0;
  assign issue_valid = state == ISSUE;
  assign busy = state != IDLE;
endmodule
